// File: rtl/axi_stripe_read_n_pkg.sv
// Shared definitions for the striped burst reader.
//   state_t   : controller state {IDLE, BUSY}
//   sel_width : stripe-index width for a given subordinate count
//   DEFAULT_* : default stripe configuration
package axi_stripe_read_n_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEFAULT_NUM_S = 2;
  localparam int DEFAULT_SEL_W = $clog2(DEFAULT_NUM_S);

  // A single subordinate would give a zero-width index; keep it at least 1 bit.
  function automatic int sel_width(input int num_s);
    return (num_s < 2) ? 1 : $clog2(num_s);
  endfunction

endpackage

// File: rtl/axi_stripe_read_n.sv
// Read-only burst splitter: one manager burst is striped word-by-word across
// NUM_S single-word subordinates in round-robin order, and the responses are
// reassembled into one in-order stream with RLAST.
//
// Ports
//   axi_clk, axi_reset         clock, asynchronous active-high reset
//   in_axi_ar*                 manager request (start word address, beats-1)
//   in_axi_r*                  manager read data stream
//   out_axi_ar*                per-subordinate request, NUM_S lanes packed
//   out_axi_r*                 per-subordinate responses, NUM_S lanes packed
module axi_stripe_read_n
  import axi_stripe_read_n_pkg::*;
#(
  parameter int NUM_S            = 2,
  parameter int AXI_ADDR_WIDTH   = 20,
  parameter int AXI_DATA_WIDTH   = 16,
  parameter int AXI_ARLENW_WIDTH = 8
) (
  input  logic                               axi_clk,
  input  logic                               axi_reset,
  input  logic [AXI_ADDR_WIDTH-1:0]          in_axi_araddr,
  input  logic [AXI_ARLENW_WIDTH-1:0]        in_axi_arlenw,
  input  logic                               in_axi_arvalid,
  output logic                               in_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]          in_axi_rdata,
  output logic [1:0]                         in_axi_rresp,
  output logic                               in_axi_rvalid,
  input  logic                               in_axi_rready,
  output logic                               in_axi_rlast,
  output logic [NUM_S*AXI_ADDR_WIDTH-1:0]    out_axi_araddr,
  output logic [NUM_S-1:0]                   out_axi_arvalid,
  input  logic [NUM_S-1:0]                   out_axi_arready,
  input  logic [NUM_S*AXI_DATA_WIDTH-1:0]    out_axi_rdata,
  input  logic [NUM_S*2-1:0]                 out_axi_rresp,
  input  logic [NUM_S-1:0]                   out_axi_rvalid,
  output logic [NUM_S-1:0]                   out_axi_rready
);

  localparam int SEL_W = sel_width(NUM_S);
  localparam int CNT_W = AXI_ARLENW_WIDTH + 1;

  state_t                      state;
  logic                        arready_q;
  logic [AXI_ADDR_WIDTH-1:0]   issue_addr;
  logic [AXI_ADDR_WIDTH-1:0]   resp_addr;
  logic [AXI_ARLENW_WIDTH-1:0] len;
  logic [CNT_W-1:0]            issue_cnt;
  logic [CNT_W-1:0]            resp_cnt;

  logic [SEL_W-1:0] issue_sel;
  logic [SEL_W-1:0] resp_sel;
  logic             busy;
  logic             issue_pend;
  logic             issue_hs;
  logic             beat_hs;
  logic             last_beat;

  assign busy      = (state == BUSY);
  assign issue_sel = issue_addr[SEL_W-1:0];
  assign resp_sel  = resp_addr[SEL_W-1:0];

  // Counters are one bit wider than len so that len = all-ones still terminates.
  assign issue_pend = busy && (issue_cnt <= {1'b0, len});
  assign issue_hs   = issue_pend && out_axi_arready[issue_sel];
  assign last_beat  = (resp_cnt == {1'b0, len});

  // Issue side: a single request lane is live at a time. The address is
  // broadcast unmodified; only the selected lane's arvalid qualifies it.
  always_comb begin
    out_axi_arvalid = '0;
    out_axi_rready  = '0;
    for (int s = 0; s < NUM_S; s++) begin
      out_axi_araddr[s*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] = issue_addr;
    end
    if (issue_pend) out_axi_arvalid[issue_sel] = 1'b1;
    if (busy)       out_axi_rready[resp_sel]   = in_axi_rready;
  end

  // Response side: consume lanes in the same round-robin order as issued,
  // which restores burst order because each subordinate answers in order.
  assign in_axi_rvalid  = busy && out_axi_rvalid[resp_sel];
  assign in_axi_rdata   = out_axi_rdata[resp_sel*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign in_axi_rresp   = out_axi_rresp[resp_sel*2 +: 2];
  assign in_axi_rlast   = last_beat && in_axi_rvalid;
  assign beat_hs        = in_axi_rvalid && in_axi_rready;
  assign in_axi_arready = arready_q;

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state      <= IDLE;
      arready_q  <= 1'b1;
      issue_addr <= '0;
      resp_addr  <= '0;
      len        <= '0;
      issue_cnt  <= '0;
      resp_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_axi_arvalid && arready_q) begin
            issue_addr <= in_axi_araddr;
            resp_addr  <= in_axi_araddr;
            len        <= in_axi_arlenw;
            issue_cnt  <= '0;
            resp_cnt   <= '0;
            arready_q  <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (issue_hs) begin
            issue_addr <= issue_addr + 1'b1;
            issue_cnt  <= issue_cnt + 1'b1;
          end
          if (beat_hs) begin
            resp_addr <= resp_addr + 1'b1;
            resp_cnt  <= resp_cnt + 1'b1;
            if (last_beat) begin
              arready_q <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: begin
          arready_q <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stripe_read_n.sv
// Bench for axi_stripe_read_n with two FIFO-backed SRAM-controller models
// whose reads return the requested address as data.
module tb_axi_stripe_read_n;

  localparam int NS = 2;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int LW = 8;

  logic              clk;
  logic              rst;
  logic [AW-1:0]     araddr;
  logic [LW-1:0]     arlenw;
  logic              arvalid;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic              rlast;
  logic [NS*AW-1:0]  o_araddr;
  logic [NS-1:0]     o_arvalid;
  logic [NS-1:0]     o_arready;
  logic [NS*DW-1:0]  o_rdata;
  logic [NS*2-1:0]   o_rresp;
  logic [NS-1:0]     o_rvalid;
  logic [NS-1:0]     o_rready;

  int total = 0;
  int bad   = 0;

  axi_stripe_read_n #(
    .NUM_S(NS), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ARLENW_WIDTH(LW)
  ) dut (
    .axi_clk(clk), .axi_reset(rst),
    .in_axi_araddr(araddr), .in_axi_arlenw(arlenw),
    .in_axi_arvalid(arvalid), .in_axi_arready(arready),
    .in_axi_rdata(rdata), .in_axi_rresp(rresp),
    .in_axi_rvalid(rvalid), .in_axi_rready(rready), .in_axi_rlast(rlast),
    .out_axi_araddr(o_araddr), .out_axi_arvalid(o_arvalid),
    .out_axi_arready(o_arready), .out_axi_rdata(o_rdata),
    .out_axi_rresp(o_rresp), .out_axi_rvalid(o_rvalid),
    .out_axi_rready(o_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Subordinate models: 4-deep in-order FIFO, one cycle read latency,
  // data = low bits of address, rresp = address[1:0].
  for (genvar s = 0; s < NS; s++) begin : g_sub
    logic [AW-1:0] mem [4];
    logic [1:0]    wp, rp;
    logic [2:0]    cnt;
    logic          push, pop;
    assign push = o_arvalid[s] && o_arready[s];
    assign pop  = o_rvalid[s] && o_rready[s];
    assign o_arready[s] = (cnt != 3'd4);
    assign o_rvalid[s]  = (cnt != 3'd0);
    assign o_rdata[s*DW +: DW] = mem[rp][DW-1:0];
    assign o_rresp[s*2 +: 2]   = mem[rp][1:0];
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) begin
          mem[wp] <= o_araddr[s*AW +: AW];
          wp      <= wp + 2'd1;
        end
        if (pop) rp <= rp + 2'd1;
        cnt <= cnt + {2'b0, push} - {2'b0, pop};
      end
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [15:0]   rpat;      // rready per cycle after acceptance, bit = cycle % 16
    logic [NS-1:0] first_arv; // lane expected to receive the first request
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int   k;
    int   cyc;
    int   first_cyc;
    int   last_cyc;
    logic seen_arv;
    logic [DW-1:0] exp_d;
    k = 0; cyc = 0; first_cyc = -1; last_cyc = -1; seen_arv = 1'b0;
    @(negedge clk);
    chk("arready_before_req", {31'b0, arready}, 32'd1);
    araddr  = v.addr;
    arlenw  = v.len;
    arvalid = 1'b1;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    while (k <= int'(v.len) && cyc < 100) begin
      rready = v.rpat[cyc % 16];
      @(negedge clk);
      chk("arready_busy", {31'b0, arready}, 32'd0);
      chk("arvalid_onehot0", {31'b0, $onehot0(o_arvalid)}, 32'd1);
      if (!seen_arv && |o_arvalid) begin
        seen_arv = 1'b1;
        chk("first_lane", {30'b0, o_arvalid}, {30'b0, v.first_arv});
        chk("first_lane_addr",
            {12'b0, (v.first_arv[1] ? o_araddr[AW +: AW] : o_araddr[0 +: AW])},
            {12'b0, v.addr});
      end
      if (rvalid) begin
        exp_d = v.exp_first + DW'(k);
        chk("rdata", {16'b0, rdata}, {16'b0, exp_d});
        chk("rresp", {30'b0, rresp}, {30'b0, exp_d[1:0]});
        chk("rlast", {31'b0, rlast}, {31'b0, (k == int'(v.len))});
        if (rready) begin
          if (k == 0) first_cyc = cyc;
          if (k == int'(v.len)) begin
            last_cyc = cyc;
            chk("last_word", {16'b0, rdata}, {16'b0, v.exp_last});
          end
          k++;
        end
      end else begin
        chk("rlast_idle", {31'b0, rlast}, 32'd0);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 100) begin
      bad++;
      total++;
      $display("FAIL burst_timeout: got %0d beats expected %0d", k, int'(v.len) + 1);
    end
    if (v.rpat == 16'hFFFF) begin
      chk("first_beat_latency", first_cyc, 32'd1);
      chk("back_to_back", last_cyc - first_cyc, {24'b0, v.len});
    end
    @(negedge clk);
    chk("rvalid_after_last", {31'b0, rvalid}, 32'd0);
    chk("arready_after_last", {31'b0, arready}, 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{addr: 20'h01000, len: 8'd1, rpat: 16'hFFFF, first_arv: 2'b01, exp_first: 16'h1000, exp_last: 16'h1001};
    vecs[1] = '{addr: 20'h0A000, len: 8'd3, rpat: 16'hFFFF, first_arv: 2'b01, exp_first: 16'hA000, exp_last: 16'hA003};
    vecs[2] = '{addr: 20'h0B000, len: 8'd3, rpat: 16'hFFFF, first_arv: 2'b01, exp_first: 16'hB000, exp_last: 16'hB003};
    vecs[3] = '{addr: 20'h0A000, len: 8'd3, rpat: 16'hAAAA, first_arv: 2'b01, exp_first: 16'hA000, exp_last: 16'hA003};
    vecs[4] = '{addr: 20'h02001, len: 8'd2, rpat: 16'hFFFF, first_arv: 2'b10, exp_first: 16'h2001, exp_last: 16'h2003};

    rst = 1'b1; arvalid = 1'b0; araddr = '0; arlenw = '0; rready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", {31'b0, arready}, 32'd1);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rlast", {31'b0, rlast}, 32'd0);
    chk("rst_arvalid", {30'b0, o_arvalid}, 32'd0);
    chk("rst_rready", {30'b0, o_rready}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_burst(vecs[i]);

    // Reset in the middle of a burst, away from any clock edge.
    @(negedge clk);
    araddr = 20'h0A000; arlenw = 8'd3; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk);
    #1 arvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_burst_rvalid", {31'b0, rvalid}, 32'd1);
    chk("mid_burst_arready", {31'b0, arready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_arready", {31'b0, arready}, 32'd1);
    chk("async_rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("async_rst_rlast", {31'b0, rlast}, 32'd0);
    chk("async_rst_arvalid", {30'b0, o_arvalid}, 32'd0);
    chk("async_rst_rready", {30'b0, o_rready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_burst('{addr: 20'h03000, len: 8'd1, rpat: 16'hFFFF, first_arv: 2'b01,
                exp_first: 16'h3000, exp_last: 16'h3001});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_stripe_read_n.md
# axi_stripe_read_n

Read-only AXI-style burst splitter that stripes one incoming burst across NUM_S subordinate read channels, one word per subordinate in round-robin order. It sits between a single read manager and NUM_S identical single-word SRAM controllers. It reassembles the subordinate responses into one in-order, back-to-back data stream with RLAST. The subordinates' latencies overlap, so the manager sees one beat per cycle.

## Interface
- NUM_S, 2: number of subordinate ports; power of two, ≥2.
- AXI_ADDR_WIDTH, 20: word-address width.
- AXI_DATA_WIDTH, 16: data width.
- AXI_ARLENW_WIDTH, 8: width of the burst-length field.
- Clock and reset: one clock; reset is asynchronous and active-high.
- axi_clk  in  1  clock; all logic on its rising edge.
- axi_reset  in  1  asynchronous, active-high reset.
- in_axi_araddr  in  AXI_ADDR_WIDTH  burst start word address.
- in_axi_arlenw  in  AXI_ARLENW_WIDTH  zero-based beat count; beats = arlenw+1.
- in_axi_arvalid / in_axi_arready  in / out  1  request handshake.
- in_axi_rdata  out  AXI_DATA_WIDTH  read data.
- in_axi_rresp  out  2  response, passed through from the active subordinate.
- in_axi_rvalid / in_axi_rready  out / in  1  data handshake.
- in_axi_rlast  out  1  high on the final beat.
- out_axi_araddr  out  NUM_S×AXI_ADDR_WIDTH  per-subordinate address.
- out_axi_arvalid / out_axi_arready  out / in  NUM_S  per-subordinate request handshake.
- out_axi_rdata  in  NUM_S×AXI_DATA_WIDTH  per-subordinate data.
- out_axi_rresp  in  NUM_S×2  per-subordinate response.
- out_axi_rvalid / out_axi_rready  in / out  NUM_S  per-subordinate data handshake.

## Operation
- States: IDLE and BUSY.
- **IDLE**
  - in_axi_arready=1.
  - On arvalid&&arready: latch araddr into issue_addr and resp_addr, latch arlenw into len, clear issue_cnt and resp_cnt, go to BUSY.
- **BUSY, issue side**
  - While issue_cnt ≤ len: present out_axi_arvalid on subordinate s=issue_addr[log2(NUM_S)-1:0], with out_axi_araddr[s]=issue_addr (full address, unmodified).
  - Hold valid and address stable until out_axi_arready[s].
  - On handshake: issue_addr++, issue_cnt++, and move to the next subordinate in the same cycle window.
  - At most one arvalid is asserted at a time.
- **BUSY, response side**
  - Active subordinate r=resp_addr[log2(NUM_S)-1:0].
  - in_axi_rvalid=out_axi_rvalid[r]; in_axi_rdata and in_axi_rresp are muxed combinationally from r.
  - out_axi_rready[r]=in_axi_rready; all other rready bits are 0.
  - in_axi_rlast=(resp_cnt==len)&&rvalid.
  - On each beat handshake: resp_addr++, resp_cnt++.
  - The handshake of the last beat returns the block to IDLE.
- Beat k of a burst always carries the word at araddr+k. Ordering is guaranteed by round-robin consumption, because each subordinate returns its responses in order.
- Arithmetic: address counters wrap modulo 2^AXI_ADDR_WIDTH. Counters are AXI_ARLENW_WIDTH+1 bits wide, so arlenw=all-ones is legal.
- An unaligned araddr is legal; striping starts at subordinate araddr mod NUM_S.

## Timing
- **Reset values:** state=IDLE; in_axi_arready=1; in_axi_rvalid=0; in_axi_rlast=0; out_axi_arvalid=0; out_axi_rready=0; all counters 0.
- **Reset mid-burst:** aborts immediately. Outstanding subordinate responses are not drained; the subordinates are reset with the block.
- in_axi_arready is registered and is 0 for the whole of BUSY. It returns to 1 on the cycle after the last-beat handshake.
- **Latency:** the first beat comes at subordinate latency plus one issue cycle.
- **Throughput:** with rready held high and subordinates accepting one request per cycle, beats are back-to-back, one per cycle, with no bubbles.
- **rready low:** the stream stalls; rdata, rresp and rlast stay stable. Issuing continues but self-limits through the subordinate arready.
- in_axi_rvalid is 0 on the cycle after the last beat.

## Structure
- Shared package holds the state enum {IDLE, BUSY} and a localparam for the stripe-index width $clog2(NUM_S).
- No sub-module is needed. A small round-robin pointer/counter may be factored out as stripe_ptr, one instance for the issue side and one for the response side.

## Test plan
Each case uses NUM_S=2 SRAM-controller subordinates whose uninitialized reads return the address.
- araddr=0x1000, arlenw=1, rready=1 -> data 0x1000 then 0x1001 on consecutive cycles; rlast only on the second beat; rvalid=0 next cycle; arready returns to 1.
- araddr=0xA000, arlenw=3 -> data 0xA000, A001, A002, A003 back-to-back; rlast only on A003; then rvalid=0 and arready=1.
- A000/len3 burst, then after arready a new request at 0xB000/len3 -> second burst returns B000–B003 in order with correct rlast and no stale data.
- 0xA000/len3 with rready toggled 1,0,1,0 -> every word delivered exactly once in order; data held stable while rready=0.
- Unaligned araddr=0x2001, arlenw=2 -> data 0x2001, 0x2002, 0x2003; the first request goes to subordinate 1.
- Reset asserted mid-burst -> all outputs return to reset values asynchronously; a subsequent 0x3000/len1 burst completes correctly.
